// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: opcodes, FSM states,
// program start addresses and the branch target table.
package fetch_sequencer_pkg;

  localparam logic [3:0] kHALT  = 4'b1111;
  localparam logic [3:0] kLOAD  = 4'b0110;
  localparam logic [3:0] kJEQ   = 4'b1010;
  localparam logic [3:0] kSTORE = 4'b0111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    RUN    = 3'd2,
    LDWAIT = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [9:0] kStartAddr [4] = '{10'd0, 10'd128, 10'd256, 10'd384};

  // Branch targets step by 8 from 16 so every entry is distinct and aligned.
  localparam logic [9:0] kBranchLut [32] = '{
    10'd16,  10'd24,  10'd32,  10'd40,  10'd48,  10'd56,  10'd64,  10'd72,
    10'd80,  10'd88,  10'd96,  10'd104, 10'd112, 10'd120, 10'd128, 10'd136,
    10'd144, 10'd152, 10'd160, 10'd168, 10'd176, 10'd184, 10'd192, 10'd200,
    10'd208, 10'd216, 10'd224, 10'd232, 10'd240, 10'd248, 10'd256, 10'd264
  };

endpackage

// File: rtl/fetch_sequencer_branch_lut.sv
// Combinational branch target lookup indexed by the low instruction bits.
module branch_lut
  import fetch_sequencer_pkg::*;
(
  input  logic [4:0] idx,
  output logic [9:0] target
);

  assign target = kBranchLut[idx];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: run/halt FSM, program counter, load stall
// and a saturating per-run cycle counter.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  ProgSel,
  input  logic [8:0]  Instruction,
  input  logic        Zero,
  output logic [9:0]  ProgCtr,
  output logic        InstrValid,
  output logic        Stall,
  output logic        Done,
  output logic [15:0] CycleCount
);

  state_t     state, state_nxt;
  logic [9:0] pc_nxt;
  logic [9:0] branch_target;
  logic [3:0] opcode;
  logic       restart;
  logic       halt;

  assign opcode = Instruction[8:5];

  branch_lut u_branch_lut (
    .idx    (Instruction[4:0]),
    .target (branch_target)
  );

  always_comb begin
    state_nxt  = state;
    pc_nxt     = ProgCtr;
    InstrValid = 1'b0;
    Stall      = 1'b0;
    restart    = 1'b0;
    halt       = 1'b0;
    case (state)
      IDLE, HALTED: restart = Start;
      ARMED: if (!Start) state_nxt = RUN;
      RUN: begin
        if (Start) restart = 1'b1;
        else begin
          case (opcode)
            kHALT: begin
              state_nxt = HALTED;
              halt      = 1'b1;
            end
            kLOAD: begin
              state_nxt = LDWAIT;
              Stall     = 1'b1;
            end
            kJEQ: begin
              InstrValid = 1'b1;
              pc_nxt     = Zero ? branch_target : ProgCtr + 10'd1;
            end
            default: begin
              InstrValid = 1'b1;
              pc_nxt     = ProgCtr + 10'd1;
            end
          endcase
        end
      end
      LDWAIT: begin
        if (Start) restart = 1'b1;
        else begin
          state_nxt  = RUN;
          InstrValid = 1'b1;
          pc_nxt     = ProgCtr + 10'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (restart) begin
      state_nxt = ARMED;
      pc_nxt    = kStartAddr[ProgSel];
    end
    // Reset suppresses any commit or stall in the same cycle.
    if (Reset) begin
      InstrValid = 1'b0;
      Stall      = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= 10'd0;
      Done       <= 1'b0;
      CycleCount <= 16'd0;
    end else begin
      state   <= state_nxt;
      ProgCtr <= pc_nxt;
      if (restart) begin
        CycleCount <= 16'd0;
        Done       <= 1'b0;
      end else begin
        if ((state == RUN || state == LDWAIT) && CycleCount != 16'hFFFF)
          CycleCount <= CycleCount + 16'd1;
        if (halt) Done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  ProgSel;
  logic [8:0]  Instruction;
  logic        Zero;
  logic [9:0]  ProgCtr;
  logic        InstrValid;
  logic        Stall;
  logic        Done;
  logic [15:0] CycleCount;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] ALU  = 9'b0000_00101;
  localparam logic [8:0] LOAD = 9'b0110_00000;
  localparam logic [8:0] HALT = 9'b1111_00000;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
    .Instruction(Instruction), .Zero(Zero), .ProgCtr(ProgCtr),
    .InstrValid(InstrValid), .Stall(Stall), .Done(Done), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pulse Start for one cycle, then release; returns with the FSM in RUN.
  task automatic arm(input logic [1:0] sel);
    Start = 1'b1; ProgSel = sel; Instruction = ALU; Zero = 1'b0;
    tick();
    Start = 1'b0;
    tick();
  endtask

  task automatic run_alu(input int n);
    Instruction = ALU;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; ProgSel = 2'd2; Instruction = ALU; Zero = 1'b0;
    tick();
    Reset = 1'b0; Start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (ProgCtr !== 10'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", ProgCtr); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (InstrValid !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL reset_iv_stall got %b%b want 00", InstrValid, Stall); end
    checks++; if (CycleCount !== 16'd0) begin errors++; $display("FAIL reset_cc got %0d want 0", CycleCount); end
  endtask

  task automatic test_start();
    Start = 1'b1; ProgSel = 2'd1; Instruction = ALU;
    tick();
    checks++; if (ProgCtr !== 10'd128) begin errors++; $display("FAIL start_pc_armed got %0d want 128", ProgCtr); end
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL start_iv_armed got %b want 0", InstrValid); end
    tick();
    checks++; if (ProgCtr !== 10'd128) begin errors++; $display("FAIL start_pc_hold got %0d want 128", ProgCtr); end
    Start = 1'b0;
    tick();
    #1;
    checks++; if (ProgCtr !== 10'd128 || InstrValid !== 1'b1) begin errors++; $display("FAIL start_run1 got pc=%0d iv=%b want pc=128 iv=1", ProgCtr, InstrValid); end
    tick();
    checks++; if (ProgCtr !== 10'd129) begin errors++; $display("FAIL start_pc_inc1 got %0d want 129", ProgCtr); end
    tick();
    checks++; if (ProgCtr !== 10'd130) begin errors++; $display("FAIL start_pc_inc2 got %0d want 130", ProgCtr); end
    checks++; if (CycleCount !== 16'd2) begin errors++; $display("FAIL start_cc got %0d want 2", CycleCount); end
  endtask

  task automatic test_jeq();
    arm(2'd0); run_alu(5);
    checks++; if (ProgCtr !== 10'd5) begin errors++; $display("FAIL jeq_setup_pc got %0d want 5", ProgCtr); end
    Instruction = {4'b1010, 5'd3}; Zero = 1'b1;
    #1;
    checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL jeq_iv got %b want 1", InstrValid); end
    tick();
    checks++; if (ProgCtr !== 10'd40) begin errors++; $display("FAIL jeq_taken got %0d want 40", ProgCtr); end
    Instruction = {4'b1010, 5'd31};
    tick();
    checks++; if (ProgCtr !== 10'd264) begin errors++; $display("FAIL jeq_lut31 got %0d want 264", ProgCtr); end
    arm(2'd0); run_alu(5);
    Instruction = {4'b1010, 5'd3}; Zero = 1'b0;
    tick();
    checks++; if (ProgCtr !== 10'd6) begin errors++; $display("FAIL jeq_not_taken got %0d want 6", ProgCtr); end
  endtask

  task automatic test_load();
    arm(2'd0); run_alu(10);
    checks++; if (ProgCtr !== 10'd10 || CycleCount !== 16'd10) begin errors++; $display("FAIL load_setup got pc=%0d cc=%0d want 10/10", ProgCtr, CycleCount); end
    Instruction = LOAD;
    #1;
    checks++; if (Stall !== 1'b1 || InstrValid !== 1'b0) begin errors++; $display("FAIL load_stall got stall=%b iv=%b want 1/0", Stall, InstrValid); end
    tick();
    checks++; if (ProgCtr !== 10'd10 || Stall !== 1'b0 || InstrValid !== 1'b1) begin errors++; $display("FAIL load_wait got pc=%0d stall=%b iv=%b want 10/0/1", ProgCtr, Stall, InstrValid); end
    Instruction = ALU;
    tick();
    checks++; if (ProgCtr !== 10'd11) begin errors++; $display("FAIL load_pc got %0d want 11", ProgCtr); end
    checks++; if (CycleCount !== 16'd12) begin errors++; $display("FAIL load_cc got %0d want 12", CycleCount); end
  endtask

  task automatic test_halt();
    arm(2'd0); run_alu(20);
    Instruction = HALT;
    #1;
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL halt_iv got %b want 0", InstrValid); end
    tick();
    checks++; if (Done !== 1'b1 || ProgCtr !== 10'd20 || CycleCount !== 16'd21) begin errors++; $display("FAIL halt_edge got done=%b pc=%0d cc=%0d want 1/20/21", Done, ProgCtr, CycleCount); end
    Instruction = ALU;
    tick(); tick();
    checks++; if (Done !== 1'b1 || ProgCtr !== 10'd20 || CycleCount !== 16'd21 || InstrValid !== 1'b0) begin errors++; $display("FAIL halt_frozen got done=%b pc=%0d cc=%0d iv=%b want 1/20/21/0", Done, ProgCtr, CycleCount, InstrValid); end
    Start = 1'b1; ProgSel = 2'd2;
    tick();
    Start = 1'b0;
    checks++; if (Done !== 1'b0 || ProgCtr !== 10'd256 || CycleCount !== 16'd0) begin errors++; $display("FAIL halt_restart got done=%b pc=%0d cc=%0d want 0/256/0", Done, ProgCtr, CycleCount); end
    tick();
  endtask

  task automatic test_restart();
    arm(2'd0); run_alu(4);
    Start = 1'b1; ProgSel = 2'd1;
    #1;
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL restart_iv got %b want 0", InstrValid); end
    tick();
    Start = 1'b0;
    checks++; if (ProgCtr !== 10'd128 || CycleCount !== 16'd0) begin errors++; $display("FAIL restart_pc got pc=%0d cc=%0d want 128/0", ProgCtr, CycleCount); end
    tick();
  endtask

  task automatic test_wrap();
    arm(2'd3); run_alu(639);
    checks++; if (ProgCtr !== 10'h3FF) begin errors++; $display("FAIL wrap_setup got %0d want 1023", ProgCtr); end
    tick();
    checks++; if (ProgCtr !== 10'd0) begin errors++; $display("FAIL wrap_pc got %0d want 0", ProgCtr); end
  endtask

  task automatic test_reset_ldwait();
    arm(2'd0); run_alu(3);
    Instruction = LOAD;
    tick();
    Reset = 1'b1; Instruction = ALU;
    #1;
    checks++; if (InstrValid !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL rstld_iv got iv=%b stall=%b want 0/0", InstrValid, Stall); end
    tick();
    Reset = 1'b0;
    #1;
    checks++; if (ProgCtr !== 10'd0 || Done !== 1'b0 || CycleCount !== 16'd0 || InstrValid !== 1'b0) begin errors++; $display("FAIL rstld_idle got pc=%0d done=%b cc=%0d iv=%b want 0/0/0/0", ProgCtr, Done, CycleCount, InstrValid); end
    tick();
    checks++; if (ProgCtr !== 10'd0 || InstrValid !== 1'b0) begin errors++; $display("FAIL rstld_stay got pc=%0d iv=%b want 0/0", ProgCtr, InstrValid); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_jeq();
    test_load();
    test_halt();
    test_restart();
    test_wrap();
    test_reset_ldwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Clk  input  1  single system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high; overrides every other input.
REQ-003 Start  input  1  run request; sequencer holds while high, commences on release.
REQ-004 ProgSel  input  2  selects program start address from package table kStartAddr.
REQ-005 Instruction  input  9  current instruction from instruction ROM; opcode = Instruction[8:5].
REQ-006 Zero  input  1  ALU zero flag for the current instruction.
REQ-007 ProgCtr  output  10  registered program counter, drives instruction ROM address.
REQ-008 InstrValid  output  1  commit enable; gates RegWrite/MemWrite of the current instruction.
REQ-009 Stall  output  1  high during the first cycle of a load; datapath holds.
REQ-010 Done  output  1  registered; high while program is halted.
REQ-011 CycleCount  output  16  registered count of executed cycles for the current run.

Function
REQ-012 FSM states SHALL be IDLE, ARMED, RUN, LDWAIT, HALTED.
REQ-013 IDLE or HALTED with Start=1 -> ARMED; ProgCtr <= kStartAddr[ProgSel]; CycleCount <= 0; Done <= 0.
REQ-014 ARMED with Start=1 -> stay, ProgCtr held; ARMED with Start=0 -> RUN.
REQ-015 RUN, opcode kHALT (4'b1111) -> HALTED next cycle, ProgCtr held, Done=1 from that edge, InstrValid=0.
REQ-016 RUN, opcode kLOAD (4'b0110) -> LDWAIT; Stall=1, InstrValid=0, ProgCtr held.
REQ-017 LDWAIT -> RUN unconditionally; Stall=0, InstrValid=1, ProgCtr <= ProgCtr+1.
REQ-018 RUN, opcode kJEQ (4'b1010) with Zero=1 -> ProgCtr <= branch_lut[Instruction[4:0]]; Zero=0 -> ProgCtr+1.
REQ-019 RUN, any other opcode -> ProgCtr <= ProgCtr+1, InstrValid=1, Stall=0.
REQ-020 ProgCtr arithmetic modulo 2^10; 10'h3FF+1 wraps to 0, no flag.
REQ-021 InstrValid and Stall combinational from state and opcode; both 0 in IDLE, ARMED, HALTED.
REQ-022 CycleCount increments each cycle in RUN or LDWAIT; saturates at 16'hFFFF.
REQ-023 Start=1 in RUN or LDWAIT -> ARMED (restart) with REQ-013 updates; in-flight instruction not committed (InstrValid=0 that cycle).
REQ-024 Done held in HALTED until Start or Reset; ProgCtr and CycleCount frozen in HALTED.

Reset
REQ-025 Reset=1 at a clock edge -> state IDLE, ProgCtr=0, Done=0, CycleCount=0, regardless of state or Start.
REQ-026 During Reset cycle and in IDLE, InstrValid=0, Stall=0.
REQ-027 Reset asserted mid-load (LDWAIT) SHALL abort the load; no commit occurs.

Structure
REQ-028 Shared package definitions SHALL hold opcode constants kHALT, kLOAD, kJEQ, kSTORE, the state enum, kStartAddr[4] (0, 10'd128, 10'd256, 10'd384) and the 32x10 branch target table.
REQ-029 Branch targets SHALL be produced by one combinational sub-module branch_lut (5-bit index in, 10-bit target out).
REQ-030 No other sub-modules; FSM, PC and counter reside in fetch_sequencer.

Verification
REQ-031 Reset 1 cycle, then idle 3 cycles -> ProgCtr=0, Done=0, InstrValid=0, CycleCount=0.
REQ-032 ProgSel=1, Start high 2 cycles then low, ROM returns ALU ops -> ProgCtr 128,128,129,130; InstrValid=1 from first RUN cycle.
REQ-033 In RUN at PC=5, Instruction={kJEQ,5'd3}, LUT[3]=40: Zero=1 -> PC=40; Zero=0 -> PC=6.
REQ-034 kLOAD at PC=10 -> one cycle Stall=1/InstrValid=0 at PC=10, then InstrValid=1, then PC=11; CycleCount +2.
REQ-035 kHALT at PC=20 -> Done=1 next edge, PC stays 20, CycleCount frozen; Start pulse -> Done=0, PC=kStartAddr[ProgSel].
REQ-036 PC at 10'h3FF with ALU op -> PC=0; Reset asserted in LDWAIT -> IDLE, PC=0, no InstrValid pulse.
